// File: rtl/io_busbridge_pkg.sv
// Shared types and constants for the I/O bus bridge and its local interrupt bank.
package io_busbridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0]  REG_RAW     = 2'd0;
    localparam logic [1:0]  REG_ENABLE  = 2'd1;
    localparam logic [1:0]  REG_PENDING = 2'd2;
    localparam logic [1:0]  REG_TOADDR  = 2'd3;

    localparam logic [31:0] ERR_RDATA   = 32'h0;
    localparam int unsigned CHAN_LOCAL  = 0;
    localparam int unsigned CNT_W       = 16;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/io_irqbank.sv
// Channel-0 local register bank: raw/enable/pending interrupt registers,
// last-timeout address capture, and the aggregated interrupt output.
module io_irqbank
    import io_busbridge_pkg::*;
#(
    parameter int unsigned NIRQ = 8,
    parameter int unsigned ADRW = 17
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            acc_i,
    input  logic            we_i,
    input  logic [1:0]      off_i,
    input  logic [NIRQ-1:0] wr_data_i,
    input  logic [NIRQ-1:0] wr_mask_i,
    input  logic            to_set_i,
    input  logic [ADRW-1:0] to_addr_i,
    input  logic [NIRQ-1:0] irq_i,
    output logic [31:0]     rdata_o,
    output logic            irq_o
);

    logic [NIRQ-1:0] irq_prev_q;
    logic [NIRQ-1:0] enable_q, enable_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] clr;
    logic [ADRW-1:0] toaddr_q;
    logic            irq_q;
    logic            wr_en, wr_clr;

    always_comb begin
        wr_en     = acc_i && we_i && (off_i == REG_ENABLE);
        wr_clr    = acc_i && we_i && (off_i == REG_PENDING);
        enable_d  = wr_en ? ((enable_q & ~wr_mask_i) | (wr_data_i & wr_mask_i)) : enable_q;
        clr       = wr_clr ? (wr_data_i & wr_mask_i) : '0;
        // New rising edges are OR-ed in after the clear so a coincident edge survives.
        pending_d = (pending_q & ~clr) | (irq_i & ~irq_prev_q);
    end

    always_comb begin
        rdata_o = '0;
        case (off_i)
            REG_RAW:     rdata_o = 32'(irq_i);
            REG_ENABLE:  rdata_o = 32'(enable_q);
            REG_PENDING: rdata_o = 32'(pending_q);
            REG_TOADDR:  rdata_o = 32'(toaddr_q);
            default:     rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            irq_prev_q <= '0;
            enable_q   <= '0;
            pending_q  <= '0;
            toaddr_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_prev_q <= irq_i;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            irq_q      <= |(pending_q & enable_q);
            if (to_set_i) begin
                toaddr_q <= to_addr_i;
            end
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/io_busbridge.sv
// Wishbone I/O bridge: selector decode, one registered transaction per request,
// timeout-protected downstream access, local interrupt bank on channel 0.
module io_busbridge
    import io_busbridge_pkg::*;
#(
    parameter int unsigned NCHAN   = 16,
    parameter int unsigned SELLO   = 12,
    parameter int unsigned SELW    = 4,
    parameter int unsigned ADRW    = 17,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned NIRQ    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [ADRW-1:0]     adr_i,
    input  logic [3:0]          sel_i,
    input  logic [31:0]         dat_i,
    output logic [31:0]         dat_o,
    output logic                ack_o,
    output logic                err_o,
    output logic                m_cyc_o,
    output logic [NCHAN-1:0]    m_stb_o,
    output logic                m_we_o,
    output logic [3:0]          m_sel_o,
    output logic [ADRW-1:0]     m_adr_o,
    output logic [31:0]         m_dat_o,
    input  logic [NCHAN*32-1:0] m_dat_i,
    input  logic [NCHAN-1:0]    m_ack_i,
    input  logic [NIRQ-1:0]     irq_i,
    output logic                irq_o
);

    state_e           state_q, state_d;
    logic [SELW-1:0]  chan_q;
    logic [CNT_W-1:0] cnt_q;
    logic             m_we_q;
    logic [3:0]       m_sel_q;
    logic [ADRW-1:0]  m_adr_q;
    logic [31:0]      m_dat_q;
    logic [31:0]      dat_q;

    logic             req, unmapped, local_ch, ch_ack, to_hit;
    logic [31:0]      ch_rdata, loc_rdata;

    assign req      = cyc_i && stb_i;
    assign unmapped = 32'(adr_i[SELLO +: SELW]) >= 32'(NCHAN);
    assign local_ch = (chan_q == SELW'(CHAN_LOCAL));

    always_comb begin
        ch_rdata = '0;
        ch_ack   = 1'b0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            if (chan_q == SELW'(k)) begin
                ch_rdata = m_dat_i[32*k +: 32];
                ch_ack   = m_ack_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        to_hit  = 1'b0;
        case (state_q)
            ST_IDLE: if (req) state_d = unmapped ? ST_ERR : ST_BUSY;
            ST_BUSY: begin
                if (local_ch || ch_ack) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    to_hit  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_o   = (state_q == ST_DONE);
        err_o   = (state_q == ST_ERR);
        m_cyc_o = (state_q == ST_BUSY) && !local_ch;
        m_stb_o = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            m_stb_o[k] = m_cyc_o && (chan_q == SELW'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            chan_q  <= '0;
            cnt_q   <= '0;
            m_we_q  <= 1'b0;
            m_sel_q <= '0;
            m_adr_q <= '0;
            m_dat_q <= '0;
            dat_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (req) begin
                    chan_q  <= adr_i[SELLO +: SELW];
                    cnt_q   <= '0;
                    m_we_q  <= we_i;
                    m_sel_q <= sel_i;
                    m_adr_q <= adr_i;
                    m_dat_q <= dat_i;
                    if (unmapped && !we_i) dat_q <= ERR_RDATA;
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (!m_we_q) begin
                        if (state_d == ST_DONE)     dat_q <= local_ch ? loc_rdata : ch_rdata;
                        else if (state_d == ST_ERR) dat_q <= ERR_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dat_o   = dat_q;
    assign m_we_o  = m_we_q;
    assign m_sel_o = m_sel_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;

    io_irqbank #(
        .NIRQ (NIRQ),
        .ADRW (ADRW)
    ) u_irqbank (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .acc_i     ((state_q == ST_BUSY) && local_ch),
        .we_i      (m_we_q),
        .off_i     (m_adr_q[3:2]),
        .wr_data_i (m_dat_q[NIRQ-1:0]),
        .wr_mask_i (NIRQ'(byte_mask(m_sel_q))),
        .to_set_i  (to_hit),
        .to_addr_i (m_adr_q),
        .irq_i     (irq_i),
        .rdata_o   (loc_rdata),
        .irq_o     (irq_o)
    );

endmodule

// File: tb/tb_io_busbridge.sv
// Bench for io_busbridge: directed vector table, hand sequences for irq/late-ack/reset,
// then randomized transactions against a behavioural model of the bridge.
module tb_io_busbridge;

    localparam int unsigned NCHAN   = 10;
    localparam int unsigned SELLO   = 12;
    localparam int unsigned SELW    = 4;
    localparam int unsigned ADRW    = 17;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned NIRQ    = 8;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                cyc_i, stb_i, we_i;
    logic [ADRW-1:0]     adr_i;
    logic [3:0]          sel_i;
    logic [31:0]         dat_i;
    logic [31:0]         dat_o;
    logic                ack_o, err_o, m_cyc_o;
    logic [NCHAN-1:0]    m_stb_o;
    logic                m_we_o;
    logic [3:0]          m_sel_o;
    logic [ADRW-1:0]     m_adr_o;
    logic [31:0]         m_dat_o;
    logic [NCHAN*32-1:0] m_dat_i;
    logic [NCHAN-1:0]    m_ack_i;
    logic [NIRQ-1:0]     irq_i;
    logic                irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    io_busbridge #(
        .NCHAN   (NCHAN),
        .SELLO   (SELLO),
        .SELW    (SELW),
        .ADRW    (ADRW),
        .TIMEOUT (TIMEOUT),
        .NIRQ    (NIRQ)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .sel_i   (sel_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_sel_o (m_sel_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_dat_i (m_dat_i),
        .m_ack_i (m_ack_i),
        .irq_i   (irq_i),
        .irq_o   (irq_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One request; cycle numbers count from the sampling edge (cycle 0).
    // lat = cycle in which the slave acks (-1 = never); ack_ch < 0 means the addressed channel.
    task automatic txn(input logic [ADRW-1:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat, input int lat, input int ack_ch,
                       input int irq_at, input logic [NIRQ-1:0] irq_val,
                       output int ack_c, output int err_c, output logic [31:0] rd,
                       output logic [NCHAN-1:0] stb_seen, output logic irq_pre);
        int ackc;
        ackc = (ack_ch < 0) ? int'(adr[SELLO +: SELW]) : ack_ch;
        @(negedge clk);
        irq_pre = irq_o;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        m_ack_i = '0;
        if (irq_at == 0) irq_i = irq_val;
        ack_c = -1; err_c = -1; rd = '0; stb_seen = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            m_ack_i = '0;
            if (c == irq_at) irq_i = irq_val;
            stb_seen |= m_stb_o;
            if (ack_o || err_o) begin
                if (ack_o) ack_c = c;
                if (err_o) err_c = c;
                rd = dat_o;
                cyc_i = 1'b0; stb_i = 1'b0;
                break;
            end
            if (c == lat && ackc < int'(NCHAN)) begin
                m_ack_i[ackc] = 1'b1;
                m_dat_i[32*ackc +: 32] = dat;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    typedef struct {
        logic [ADRW-1:0]  adr;
        logic             we;
        logic [3:0]       sel;
        logic [31:0]      dat;
        int               lat;
        int               ackch;
        int               exp_ack;
        int               exp_err;
        logic [31:0]      exp_dat;
        logic [NCHAN-1:0] exp_stb;
    } vec_t;

    vec_t             vec [13];
    int               ack_c, err_c;
    logic [31:0]      rd;
    logic [NCHAN-1:0] stb_seen;
    logic             irq_pre;

    // behavioural model state
    logic [NIRQ-1:0]  m_en, m_pend, m_irq;
    logic [ADRW-1:0]  m_toa;
    logic [31:0]      m_dout;

    initial begin
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; sel_i = '0;
        dat_i = '0; m_dat_i = '0; m_ack_i = '0; irq_i = '0;

        vec[0]  = '{17'h00004, 1'b1, 4'h1, 32'hFFFF_FF05, -1, -1,  2, -1, 32'h0,         10'h000};
        vec[1]  = '{17'h00004, 1'b0, 4'hF, 32'h0,         -1, -1,  2, -1, 32'h05,        10'h000};
        vec[2]  = '{17'h03010, 1'b0, 4'hF, 32'hCAFE_0003,  4, -1,  5, -1, 32'hCAFE_0003, 10'h008};
        vec[3]  = '{17'h05020, 1'b1, 4'hF, 32'h1111_2222, -1, -1, -1, 17, 32'hCAFE_0003, 10'h020};
        vec[4]  = '{17'h0000C, 1'b0, 4'hF, 32'h0,         -1, -1,  2, -1, 32'h0000_5020, 10'h000};
        vec[5]  = '{17'h0C000, 1'b0, 4'hF, 32'h0,          1, -1, -1,  1, 32'h0,         10'h000};
        vec[6]  = '{17'h07000, 1'b0, 4'hF, 32'h1234_5677,  1, -1,  2, -1, 32'h1234_5677, 10'h080};
        vec[7]  = '{17'h09004, 1'b0, 4'hF, 32'h9999_0009, 16, -1, 17, -1, 32'h9999_0009, 10'h200};
        vec[8]  = '{17'h04008, 1'b0, 4'hF, 32'hDEAD_0004,  3,  6, -1, 17, 32'h0,         10'h010};
        vec[9]  = '{17'h0000C, 1'b0, 4'hF, 32'h0,         -1, -1,  2, -1, 32'h0000_4008, 10'h000};
        vec[10] = '{17'h10004, 1'b1, 4'hE, 32'h0000_00FF, -1, -1,  2, -1, 32'h0000_4008, 10'h000};
        vec[11] = '{17'h00004, 1'b0, 4'hF, 32'h0,         -1, -1,  2, -1, 32'h05,        10'h000};
        vec[12] = '{17'h00004, 1'b1, 4'hF, 32'h0000_0004, -1, -1,  2, -1, 32'h05,        10'h000};

        repeat (3) @(negedge clk);
        chk("reset ack_o", ack_o, 0);
        chk("reset err_o", err_o, 0);
        chk("reset m_cyc_o", m_cyc_o, 0);
        chk("reset m_stb_o", m_stb_o, 0);
        chk("reset dat_o", dat_o, 0);
        chk("reset m_adr_o", m_adr_o, 0);
        chk("reset irq_o", irq_o, 0);
        rst_i = 1'b1;

        for (int i = 0; i < 13; i++) begin
            txn(vec[i].adr, vec[i].we, vec[i].sel, vec[i].dat, vec[i].lat, vec[i].ackch, -1, '0,
                ack_c, err_c, rd, stb_seen, irq_pre);
            chk($sformatf("vec%0d ack_cycle", i), ack_c, vec[i].exp_ack);
            chk($sformatf("vec%0d err_cycle", i), err_c, vec[i].exp_err);
            chk($sformatf("vec%0d dat_o", i), rd, vec[i].exp_dat);
            chk($sformatf("vec%0d m_stb_o", i), stb_seen, vec[i].exp_stb);
            chk($sformatf("vec%0d irq_o", i), irq_pre, 0);
        end

        // interrupt pending / enable / W1C, ENABLE = 8'h04 now
        @(negedge clk); irq_i = 8'h04;
        @(negedge clk); irq_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("irq after pulse", irq_o, 1);
        txn(17'h00008, 1'b0, 4'hF, 32'h0, -1, -1, -1, '0, ack_c, err_c, rd, stb_seen, irq_pre);
        chk("pending read", rd, 32'h4);
        chk("pending ack_cycle", ack_c, 2);
        txn(17'h00008, 1'b1, 4'h1, 32'h4, -1, -1, -1, '0, ack_c, err_c, rd, stb_seen, irq_pre);
        repeat (2) @(negedge clk);
        chk("irq after w1c", irq_o, 0);
        @(negedge clk); irq_i = 8'h04;
        @(negedge clk); irq_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("irq after second pulse", irq_o, 1);
        txn(17'h00008, 1'b1, 4'h1, 32'h4, -1, -1, 1, 8'h04, ack_c, err_c, rd, stb_seen, irq_pre);
        irq_i = 8'h00;
        txn(17'h00008, 1'b0, 4'hF, 32'h0, -1, -1, -1, '0, ack_c, err_c, rd, stb_seen, irq_pre);
        chk("pending kept on coincident edge", rd, 32'h4);
        chk("irq kept on coincident edge", irq_pre, 1);
        txn(17'h00008, 1'b1, 4'h1, 32'h4, -1, -1, -1, '0, ack_c, err_c, rd, stb_seen, irq_pre);

        // timeout then late ack on the same channel
        txn(17'h05000, 1'b0, 4'hF, 32'h5555_5555, -1, -1, -1, '0, ack_c, err_c, rd, stb_seen, irq_pre);
        chk("timeout err_cycle", err_c, 17);
        chk("timeout read dat_o", rd, 32'h0);
        for (int i = 0; i < 3; i++) begin
            m_ack_i[5] = 1'b1;
            @(negedge clk);
            chk("late ack ignored", {ack_o, err_o}, 2'b00);
        end
        m_ack_i = '0;

        // reset in the middle of a downstream access
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 17'h02000;
        repeat (2) @(negedge clk);
        chk("busy m_cyc_o", m_cyc_o, 1);
        chk("busy m_stb_o", m_stb_o, 10'h004);
        #2 rst_i = 1'b0;
        #1;
        chk("async reset m_cyc_o", m_cyc_o, 0);
        chk("async reset m_stb_o", m_stb_o, 0);
        cyc_i = 1'b0; stb_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("no ack/err in reset", {ack_o, err_o}, 2'b00);
        end
        rst_i = 1'b1;
        txn(17'h00004, 1'b0, 4'hF, 32'h0, -1, -1, -1, '0, ack_c, err_c, rd, stb_seen, irq_pre);
        chk("enable after reset", rd, 32'h0);
        chk("enable after reset ack_cycle", ack_c, 2);

        // randomized transactions against a transaction-level model
        m_en = '0; m_pend = '0; m_irq = '0; m_toa = '0; m_dout = '0;
        for (int t = 0; t < 200; t++) begin
            int               ch, lat, e_ack, e_err;
            logic [1:0]       off;
            logic             we;
            logic [3:0]       sel;
            logic [31:0]      dat;
            logic [ADRW-1:0]  adr;
            logic [NIRQ-1:0]  nirq;
            logic [NCHAN-1:0] e_stb;
            logic             e_irq;
            ch  = $urandom_range(0, 15);
            off = 2'($urandom_range(0, 3));
            adr = {1'($urandom_range(0, 1)), 4'(ch), 8'($urandom), off, 2'($urandom)};
            we  = 1'($urandom);
            sel = 4'($urandom);
            dat = $urandom;
            lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TIMEOUT + 1));
            nirq = ($urandom_range(0, 1) == 1) ? NIRQ'($urandom) : m_irq;

            e_irq  = |(m_pend & m_en);
            m_pend = m_pend | (nirq & ~m_irq);
            m_irq  = nirq;
            e_ack = -1; e_err = -1; e_stb = '0;
            if (ch >= int'(NCHAN)) begin
                e_err = 1;
                if (!we) m_dout = 32'h0;
            end else if (ch == 0) begin
                e_ack = 2;
                if (!we) begin
                    case (off)
                        2'd0: m_dout = 32'(m_irq);
                        2'd1: m_dout = 32'(m_en);
                        2'd2: m_dout = 32'(m_pend);
                        default: m_dout = 32'(m_toa);
                    endcase
                end else if (sel[0]) begin
                    if (off == 2'd1) m_en = dat[NIRQ-1:0];
                    if (off == 2'd2) m_pend = m_pend & ~dat[NIRQ-1:0];
                end
            end else begin
                e_stb = NCHAN'(1) << ch;
                if (lat >= 1 && lat <= int'(TIMEOUT)) begin
                    e_ack = lat + 1;
                    if (!we) m_dout = dat;
                end else begin
                    e_err = TIMEOUT + 1;
                    m_toa = adr;
                    if (!we) m_dout = 32'h0;
                end
            end

            txn(adr, we, sel, dat, lat, -1, 0, nirq, ack_c, err_c, rd, stb_seen, irq_pre);
            chk($sformatf("rnd%0d ack_cycle", t), ack_c, e_ack);
            chk($sformatf("rnd%0d err_cycle", t), err_c, e_err);
            chk($sformatf("rnd%0d dat_o", t), rd, m_dout);
            chk($sformatf("rnd%0d m_stb_o", t), stb_seen, e_stb);
            chk($sformatf("rnd%0d irq_o", t), irq_pre, e_irq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
